// File: rtl/spi_input_conditioner_if.sv
// SPI pin/conditioned-signal bundle between the raw pads and the slave path.
// Ports: raw pins in; conditioned levels, edge strobes and bit counter out.
interface spi_input_conditioner_if;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       cs_fall;
  logic       cs_rise;
  logic [2:0] bit_count;
  logic       byte_done;

  modport master (
    output sclk_pin, cs_pin, mosi_pin,
    input  sclk, cs, mosi,
    input  sclk_posedge, sclk_negedge,
    input  cs_fall, cs_rise,
    input  bit_count, byte_done
  );

  modport slave (
    input  sclk_pin, cs_pin, mosi_pin,
    output sclk, cs, mosi,
    output sclk_posedge, sclk_negedge,
    output cs_fall, cs_rise,
    output bit_count, byte_done
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// SPI input front-end: synchronize + debounce sclk/cs/mosi, edge strobes,
// per-frame bit counter. Ports: clk, reset (async high), io (slave modport).
module spi_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_WAIT = 3,
  parameter int COUNTER_WIDTH = 3
) (
  input logic               clk,
  input logic               reset,
  spi_input_conditioner_if.slave io
);

  // channel order: 0 = sclk, 1 = cs, 2 = mosi
  localparam int NCH = 3;
  localparam logic [NCH-1:0] IDLE = 3'b010;
  localparam logic [COUNTER_WIDTH-1:0] LAST =
    COUNTER_WIDTH'(DEBOUNCE_WAIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE =
    COUNTER_WIDTH'(1);

  logic [NCH-1:0] pin;
  logic [NCH-1:0] s;
  logic [NCH-1:0] cond;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] sync [SYNC_STAGES];
  logic [COUNTER_WIDTH-1:0] cnt [NCH];

  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       cs_fall;
  logic       cs_rise;
  logic       byte_done;
  logic [2:0] bit_count;

  logic gated_rise;
  logic gated_fall;
  logic frame_start;
  logic frame_end;

  assign pin = {io.mosi_pin, io.cs_pin, io.sclk_pin};
  assign s   = sync[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (s[i] != cond[i]) && (cnt[i] == LAST);
    end
  end

  // gating uses the cs level held before this edge, so an sclk
  // change landing with the cs fall is dropped, with the cs rise kept
  assign gated_rise  = accept[0] &  s[0] & ~cond[1];
  assign gated_fall  = accept[0] & ~s[0] & ~cond[1];
  assign frame_start = accept[1] & ~s[1];
  assign frame_end   = accept[1] &  s[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= IDLE;
      end
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      cond <= IDLE;
    end else begin
      sync[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      for (int i = 0; i < NCH; i++) begin
        if (s[i] == cond[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cond[i] <= s[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_posedge <= 1'b0;
      sclk_negedge <= 1'b0;
      cs_fall      <= 1'b0;
      cs_rise      <= 1'b0;
      byte_done    <= 1'b0;
      bit_count    <= '0;
    end else begin
      sclk_posedge <= gated_rise;
      sclk_negedge <= gated_fall;
      cs_fall      <= frame_start;
      cs_rise      <= frame_end;
      byte_done    <= gated_rise && !frame_start &&
                      (bit_count == 3'd7);
      if (frame_start) begin
        bit_count <= '0;
      end else if (gated_rise) begin
        bit_count <= bit_count + 3'd1;
      end
    end
  end

  assign io.sclk         = cond[0];
  assign io.cs           = cond[1];
  assign io.mosi         = cond[2];
  assign io.sclk_posedge = sclk_posedge;
  assign io.sclk_negedge = sclk_negedge;
  assign io.cs_fall      = cs_fall;
  assign io.cs_rise      = cs_rise;
  assign io.bit_count    = bit_count;
  assign io.byte_done    = byte_done;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: directed + random pins vs window model.
// Ports: none; drives the interface master side and checks every cycle.
module tb_spi_input_conditioner;

  localparam int SS = 2;
  localparam int DW = 3;

  logic clk;
  logic reset;

  spi_input_conditioner_if bus ();

  spi_input_conditioner #(
    .SYNC_STAGES  (SS),
    .DEBOUNCE_WAIT(DW),
    .COUNTER_WIDTH(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sp = 0, n_sn = 0, n_cf = 0, n_cr = 0, n_bd = 0, n_hi = 0;
  logic [7:0] mbyte = 8'h00;

  // reference model state
  bit dly [3][$];
  bit win [3][$];
  int since [3];
  bit mc [3];
  bit e_sp, e_sn, e_cf, e_cr, e_bd;
  int bits;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    bit idle [3];
    idle[0] = 1'b0;
    idle[1] = 1'b1;
    idle[2] = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      dly[ch].delete();
      win[ch].delete();
      for (int j = 0; j < SS; j++) dly[ch].push_back(idle[ch]);
      since[ch] = 0;
      mc[ch] = idle[ch];
    end
    e_sp = 0; e_sn = 0; e_cf = 0; e_cr = 0; e_bd = 0;
    bits = 0;
  endtask

  // a channel's level flips once its synchronized value has
  // disagreed with it on each of the last DW edges since the last flip
  task automatic m_edge(input bit p [3]);
    bit cs_old;
    bit fl [3];
    bit sv;
    cs_old = mc[1];
    for (int ch = 0; ch < 3; ch++) begin
      sv = dly[ch][0];
      dly[ch].push_back(p[ch]);
      void'(dly[ch].pop_front());
      win[ch].push_back(sv);
      if (win[ch].size() > DW) void'(win[ch].pop_front());
      since[ch]++;
      fl[ch] = (since[ch] >= DW);
      for (int j = 0; j < win[ch].size(); j++)
        if (win[ch][j] == mc[ch]) fl[ch] = 0;
      if (fl[ch]) begin
        mc[ch] = ~mc[ch];
        since[ch] = 0;
      end
    end
    e_sp = fl[0] && mc[0] && !cs_old;
    e_sn = fl[0] && !mc[0] && !cs_old;
    e_cf = fl[1] && !mc[1];
    e_cr = fl[1] && mc[1];
    e_bd = 0;
    if (e_cf) bits = 0;
    else if (e_sp) begin
      bits++;
      e_bd = (bits % 8 == 0);
    end
  endtask

  task automatic check_all();
    chk("sclk", 32'(bus.sclk), 32'(mc[0]));
    chk("cs", 32'(bus.cs), 32'(mc[1]));
    chk("mosi", 32'(bus.mosi), 32'(mc[2]));
    chk("sclk_posedge", 32'(bus.sclk_posedge), 32'(e_sp));
    chk("sclk_negedge", 32'(bus.sclk_negedge), 32'(e_sn));
    chk("cs_fall", 32'(bus.cs_fall), 32'(e_cf));
    chk("cs_rise", 32'(bus.cs_rise), 32'(e_cr));
    chk("bit_count", 32'(bus.bit_count), 32'(bits % 8));
    chk("byte_done", 32'(bus.byte_done), 32'(e_bd));
  endtask

  // one clock: pins sampled at the edge, outputs checked at negedge
  task automatic tick();
    bit p [3];
    p[0] = bus.sclk_pin;
    p[1] = bus.cs_pin;
    p[2] = bus.mosi_pin;
    @(posedge clk);
    if (reset) m_reset();
    else m_edge(p);
    @(negedge clk);
    check_all();
    if (bus.sclk_posedge === 1'b1) begin
      n_sp++;
      mbyte = {mbyte[6:0], bus.mosi};
    end
    if (bus.sclk_negedge === 1'b1) n_sn++;
    if (bus.cs_fall === 1'b1) n_cf++;
    if (bus.cs_rise === 1'b1) n_cr++;
    if (bus.byte_done === 1'b1) n_bd++;
    if (bus.sclk === 1'b1) n_hi++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulses(input int n, input int half);
    repeat (n) begin
      bus.sclk_pin = 1'b1;
      run(half);
      bus.sclk_pin = 1'b0;
      run(half);
    end
  endtask

  int lat;
  int b_sp, b_sn, b_bd, b_hi;
  logic [7:0] tx;

  initial begin
    reset = 1'b1;
    bus.sclk_pin = 1'b0;
    bus.cs_pin   = 1'b1;
    bus.mosi_pin = 1'b0;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    run(2);
    reset = 1'b0;

    // idle pins after reset: nothing moves
    run(20);
    chk("idle_strobes", n_sp + n_sn + n_cf + n_cr + n_bd, 0);

    // cs fall latency: first sampling edge is tick 1
    bus.cs_pin = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (bus.cs_fall === 1'b1) lat = i;
    end
    chk("cs_fall_latency", lat, SS + DW);
    chk("cs_fall_bit_count", 32'(bus.bit_count), 0);
    run(6);

    // 2-clock sclk glitch rejected, 3-clock pulse accepted
    b_sp = n_sp; b_sn = n_sn; b_hi = n_hi;
    bus.sclk_pin = 1'b1;
    run(2);
    bus.sclk_pin = 1'b0;
    run(10);
    chk("glitch2_posedge", n_sp - b_sp, 0);
    chk("glitch2_level", n_hi - b_hi, 0);
    bus.sclk_pin = 1'b1;
    run(3);
    bus.sclk_pin = 1'b0;
    run(10);
    chk("pulse3_posedge", n_sp - b_sp, 1);
    chk("pulse3_negedge", n_sn - b_sn, 1);

    // fresh frame, send 0xA5 MSB first
    bus.cs_pin = 1'b1;
    run(8);
    bus.cs_pin = 1'b0;
    run(8);
    chk("new_frame_bit_count", 32'(bus.bit_count), 0);
    tx = 8'hA5;
    b_sp = n_sp; b_bd = n_bd;
    for (int i = 7; i >= 0; i--) begin
      bus.mosi_pin = tx[i];
      run(8);
      bus.sclk_pin = 1'b1;
      run(8);
      bus.sclk_pin = 1'b0;
    end
    run(8);
    chk("frame_posedges", n_sp - b_sp, 8);
    chk("frame_byte", 32'(mbyte), 32'h0000_00A5);
    chk("frame_byte_done", n_bd - b_bd, 1);
    chk("frame_bit_count", 32'(bus.bit_count), 0);

    // partial byte then cs high: count holds, sclk ignored
    pulses(3, 4);
    bus.cs_pin = 1'b1;
    run(8);
    chk("partial_hold", 32'(bus.bit_count), 3);
    b_sp = n_sp; b_sn = n_sn; b_bd = n_bd; b_hi = n_hi;
    pulses(4, 5);
    chk("ungated_posedge", n_sp - b_sp, 0);
    chk("ungated_negedge", n_sn - b_sn, 0);
    chk("ungated_byte_done", n_bd - b_bd, 0);
    chk("ungated_follows", 32'(n_hi - b_hi > 0), 1);
    chk("ungated_bit_count", 32'(bus.bit_count), 3);

    // reset in the middle of a frame
    bus.cs_pin = 1'b0;
    run(8);
    pulses(3, 4);
    chk("pre_reset_bits", 32'(bus.bit_count), 3);
    reset = 1'b1;
    #1;
    chk("async_reset_cs", 32'(bus.cs), 1);
    chk("async_reset_bits", 32'(bus.bit_count), 0);
    chk("async_reset_sclk", 32'(bus.sclk), 0);
    m_reset();
    run(3);
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (bus.cs_fall === 1'b1) lat = i;
    end
    chk("post_reset_cs_fall", lat, SS + DW);

    // random pin activity against the model
    for (int i = 0; i < 400; i++) begin
      bus.sclk_pin = 1'($urandom_range(0, 1));
      bus.mosi_pin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        bus.cs_pin = ~bus.cs_pin;
      run(int'($urandom_range(1, 6)));
    end
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
